rng_share_arbiter: RTL and testbench
====================================

// Module: rng_share_arbiter
// PURPOSE
//  Shares one 16-bit LFSR random source between NUM_REQ pixel/colour requesters.
//  Sequences the LFSR via a step enable, so the source advances only when a value is consumed.
//  Services reseed requests, substituting a non-zero default for an all-zero seed.
//  Sits between the LFSR and the image-generator blocks that need random colour data.
// PARAMETERS
//  NUM_REQ       4         number of requesters (2..8)
//  RNG_W         16        width of random value and seed
//  SEED_DEFAULT  16'h5A08  seed driven when a zero seed is requested (LFSR lock-up guard)
//  ID_W          $clog2(NUM_REQ)  localparam, requester index width
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  req         in   NUM_REQ  per-requester level request, held until its gnt bit pulses
//  seed_req    in   1        one-cycle pulse: reseed the LFSR with seed_val
//  seed_val    in   RNG_W    seed, sampled in the cycle seed_req=1
//  rng_value   in   RNG_W    current LFSR output
//  rng_step    out  1        LFSR advance enable, one cycle
//  rng_load    out  1        LFSR parallel-load enable, one cycle
//  rng_seed    out  RNG_W    value to load when rng_load=1
//  gnt         out  NUM_REQ  one-hot grant pulse
//  rsp_valid   out  1        rsp_data/rsp_id valid, one cycle, coincident with gnt
//  rsp_data    out  RNG_W    random value handed to the granted requester
//  rsp_id      out  ID_W     index of the granted requester
//  busy        out  1        1 whenever state != IDLE or a seed is pending
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE, all outputs 0, rr pointer=0, seed_pend=0, pend_seed=0.
//  - FSM states: IDLE, GRANT, SEED. Every output is registered.
//  - Seed capture: seed_req=1 in any state sets seed_pend and stores seed_val into pend_seed.
//    - A later seed_req before service overwrites pend_seed; the last value wins.
//  - IDLE:
//    - If seed_pend (or seed_req this cycle), go to SEED. Seed has priority over all requests.
//    - Else if |req, go to GRANT with winner w.
//    - Else stay in IDLE.
//  - Winner w: first set req bit searching from rr upward, wrapping NUM_REQ-1 -> 0.
//  - On the IDLE->GRANT edge, register:
//    - gnt = onehot(w), rsp_id = w, rsp_valid = 1, rsp_data = rng_value (sampled at that edge).
//    - rng_step = 1.
//    - rr = (w == NUM_REQ-1) ? 0 : w+1.
//  - GRANT (exactly 1 cycle):
//    - gnt, rsp_valid and rng_step are high for this cycle.
//    - The LFSR advances on the edge leaving GRANT. Next state is always IDLE.
//  - SEED (exactly 1 cycle):
//    - rng_load = 1.
//    - rng_seed = (pend_seed == 0) ? SEED_DEFAULT : pend_seed.
//    - seed_pend is cleared unless a new seed_req arrives in the same cycle.
//    - Next state is IDLE.
//  - Latency: req rising in IDLE at cycle t gives gnt in cycle t+1.
//  - Throughput: max one grant per 2 cycles. Successive grants never reuse an un-stepped value.
//  - rng_step and rng_load are never high together. gnt is zero or one-hot.
//  - A req dropped before grant is simply not served; no state is kept per requester.
//  - A req held through its gnt cycle is served again on a later round-robin turn.
//  - Reset asserted mid-GRANT or mid-SEED: outputs drop immediately, and the pending seed is lost.
// TESTING
//  - Reset: reset=0 mid-GRANT -> gnt, rsp_valid, rng_step=0 at once.
//    - After release with req=0: state IDLE, busy=0.
//  - Single requester: req=4'b0100, rng_value=16'h1234 -> next cycle:
//    - gnt=4'b0100, rsp_id=2, rsp_data=16'h1234, rng_step=1.
//  - Round-robin: req=4'b1111 held for 8 cycles -> grants to ids 0,1,2,3 on alternate cycles.
//    - rng_step is pulsed 4 times; no id repeats before the others are served.
//  - Seed priority: seed_req=1 with seed_val=16'hBEEF and req=4'b0001 in the same IDLE cycle:
//    - Next cycle: rng_load=1, rng_seed=16'hBEEF, gnt=0.
//    - The cycle after: IDLE. The cycle after that: gnt=4'b0001.
//  - Zero seed: seed_req with seed_val=0 -> rng_seed=16'h5A08 with rng_load=1.
//  - Seed during GRANT, overwritten: seed_req 16'h0001 in GRANT, then 16'h0002 in the next cycle
//    -> one SEED cycle, with rng_seed=16'h0002.

Source files
------------

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: shares one LFSR source between NUM_REQ requesters round-robin,
// steps the LFSR only when a value is consumed and services (zero-guarded) reseeds.
module rng_share_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned RNG_W = 16,
   parameter logic [RNG_W-1:0] SEED_DEFAULT = RNG_W'(16'h5A08),
   localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               seed_req,
   input  logic [RNG_W-1:0]   seed_val,
   input  logic [RNG_W-1:0]   rng_value,
   output logic               rng_step,
   output logic               rng_load,
   output logic [RNG_W-1:0]   rng_seed,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rsp_valid,
   output logic [RNG_W-1:0]   rsp_data,
   output logic [ID_W-1:0]    rsp_id,
   output logic               busy
);

   localparam int unsigned SUM_W = ID_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEED  = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [ID_W-1:0]    rr, rr_n;
   logic               seed_pend, seed_pend_n;
   logic [RNG_W-1:0]   pend_seed, pend_seed_n;

   logic               rng_step_n;
   logic               rng_load_n;
   logic [RNG_W-1:0]   rng_seed_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic               rsp_valid_n;
   logic [RNG_W-1:0]   rsp_data_n;
   logic [ID_W-1:0]    rsp_id_n;
   logic               busy_n;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [SUM_W-1:0]   sum;
   logic [ID_W-1:0]    idx;

   // Round-robin search: first requester at or above rr, wrapping to 0.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, rr} + SUM_W'(i);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_n     = state;
      rr_n        = rr;
      seed_pend_n = seed_pend | seed_req;
      pend_seed_n = seed_req ? seed_val : pend_seed;
      rng_step_n  = 1'b0;
      rng_load_n  = 1'b0;
      rng_seed_n  = '0;
      gnt_n       = '0;
      rsp_valid_n = 1'b0;
      rsp_data_n  = '0;
      rsp_id_n    = '0;

      unique case (state)
         IDLE: begin
            if (seed_pend || seed_req) begin
               state_n    = SEED;
               rng_load_n = 1'b1;
               rng_seed_n = (pend_seed_n == '0) ? SEED_DEFAULT : pend_seed_n;
            end else if (win_found) begin
               state_n     = GRANT;
               gnt_n       = NUM_REQ'(1) << win_id;
               rsp_id_n    = win_id;
               rsp_valid_n = 1'b1;
               rsp_data_n  = rng_value;
               rng_step_n  = 1'b1;
               rr_n        = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
         end
         GRANT: begin
            state_n = IDLE;
         end
         SEED: begin
            state_n     = IDLE;
            seed_pend_n = seed_req;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE) || seed_pend_n;
   end

   // State and output registers; reset discards any pending seed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rr        <= '0;
         seed_pend <= 1'b0;
         pend_seed <= '0;
         rng_step  <= 1'b0;
         rng_load  <= 1'b0;
         rng_seed  <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         rr        <= rr_n;
         seed_pend <= seed_pend_n;
         pend_seed <= pend_seed_n;
         rng_step  <= rng_step_n;
         rng_load  <= rng_load_n;
         rng_seed  <= rng_seed_n;
         gnt       <= gnt_n;
         rsp_valid <= rsp_valid_n;
         rsp_data  <= rsp_data_n;
         rsp_id    <= rsp_id_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter: directed stimulus pushes expected grant/load
// events, a negedge monitor pops and compares them against the DUT outputs.
module tb_rng_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic        seed_req;
   logic [15:0] seed_val;
   logic [15:0] rng_value;
   logic        rng_step;
   logic        rng_load;
   logic [15:0] rng_seed;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        busy;

   logic        set_en;
   logic [15:0] set_val;
   logic [15:0] src = 16'h0000;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      bit          is_load;
      logic [3:0]  gnt;
      logic [1:0]  id;
      logic [15:0] val;
      int          cyc;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   exp_t sb[$];
   chk_t chk_q[$];

   rng_share_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .seed_req  (seed_req),
      .seed_val  (seed_val),
      .rng_value (rng_value),
      .rng_step  (rng_step),
      .rng_load  (rng_load),
      .rng_seed  (rng_seed),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in random source: counts up on each step, loads on reload.
   always @(posedge clk) begin
      if (set_en)        src <= set_val;
      else if (rng_load) src <= rng_seed;
      else if (rng_step) src <= src + 16'd1;
   end
   assign rng_value = src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: direct snapshots first, then any DUT output activity against the scoreboard.
   always @(negedge clk) begin
      chk_t c;
      exp_t e;
      while (chk_q.size() != 0) begin
         c = chk_q.pop_front();
         chk(c.name, c.act, c.exp);
      end
      if (rsp_valid || rng_load || rng_step || (gnt != 4'b0000)) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'({gnt, rsp_valid, rng_step, rng_load}), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (e.is_load) begin
               chk("rng_load", 32'(rng_load), 32'(1));
               chk("rng_seed", 32'(rng_seed), 32'(e.val));
               chk("load_gnt", 32'(gnt), 32'(0));
               chk("load_step", 32'(rng_step), 32'(0));
            end else begin
               chk("gnt", 32'(gnt), 32'(e.gnt));
               chk("rsp_valid", 32'(rsp_valid), 32'(1));
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_data", 32'(rsp_data), 32'(e.val));
               chk("rng_step", 32'(rng_step), 32'(1));
               chk("grant_load", 32'(rng_load), 32'(0));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input bit is_load, input logic [3:0] g, input logic [1:0] id,
                           input logic [15:0] v, input int c);
      exp_t e;
      e.is_load = is_load;
      e.gnt     = g;
      e.id      = id;
      e.val     = v;
      e.cyc     = c;
      sb.push_back(e);
   endtask

   task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic set_src(input logic [15:0] v);
      set_val = v;
      set_en  = 1'b1;
      tick();
      set_en  = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      req      = 4'b0000;
      seed_req = 1'b0;
      seed_val = 16'h0000;
      set_en   = 1'b0;
      set_val  = 16'h0000;
      repeat (3) tick();

      // Reset state
      push_chk("rst_gnt", 32'(gnt), 32'(0));
      push_chk("rst_valid", 32'(rsp_valid), 32'(0));
      push_chk("rst_step", 32'(rng_step), 32'(0));
      push_chk("rst_load", 32'(rng_load), 32'(0));
      push_chk("rst_busy", 32'(busy), 32'(0));
      push_chk("rst_seed", 32'(rng_seed), 32'(0));
      push_chk("rst_data", 32'(rsp_data), 32'(0));
      reset = 1'b1;
      tick();
      tick();

      // Single requester
      set_src(16'h1234);
      req = 4'b0100;
      push_exp(1'b0, 4'b0100, 2'd2, 16'h1234, cyc + 1);
      tick();
      req = 4'b0000;
      tick();
      tick();

      // Reset asserted in the middle of a GRANT cycle
      req = 4'b0001;
      tick();
      req = 4'b0000;
      #1;
      push_chk("pre_rst_gnt", 32'(gnt), 32'(4'b0001));
      reset = 1'b0;
      #1;
      push_chk("midgrant_rst_out", 32'({gnt, rsp_valid, rng_step}), 32'(0));
      tick();
      reset = 1'b1;
      tick();
      push_chk("post_rst_busy", 32'(busy), 32'(0));
      push_chk("post_rst_gnt", 32'(gnt), 32'(0));
      tick();

      // Round-robin with all requesters held
      set_src(16'hA000);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         push_exp(1'b0, 4'(1 << k), 2'(k), 16'hA000 + 16'(k), cyc + 1 + 2 * k);
      end
      repeat (8) tick();
      req = 4'b0000;
      tick();
      tick();

      // Seed has priority over a simultaneous request
      seed_req = 1'b1;
      seed_val = 16'hBEEF;
      req      = 4'b0001;
      push_exp(1'b1, 4'b0000, 2'd0, 16'hBEEF, cyc + 1);
      push_exp(1'b0, 4'b0001, 2'd0, 16'hBEEF, cyc + 3);
      tick();
      seed_req = 1'b0;
      seed_val = 16'h0000;
      tick();
      push_chk("after_seed_busy", 32'(busy), 32'(0));
      push_chk("after_seed_gnt", 32'(gnt), 32'(0));
      tick();
      req = 4'b0000;
      tick();
      tick();

      // Zero seed replaced by the default
      seed_req = 1'b1;
      seed_val = 16'h0000;
      push_exp(1'b1, 4'b0000, 2'd0, 16'h5A08, cyc + 1);
      tick();
      seed_req = 1'b0;
      tick();
      tick();

      // Seed during GRANT, overwritten before service: one SEED with the last value
      req = 4'b0010;
      push_exp(1'b0, 4'b0010, 2'd1, 16'h5A08, cyc + 1);
      tick();
      req      = 4'b0000;
      seed_req = 1'b1;
      seed_val = 16'h0001;
      tick();
      push_chk("seed_pend_busy", 32'(busy), 32'(1));
      seed_val = 16'h0002;
      push_exp(1'b1, 4'b0000, 2'd0, 16'h0002, cyc + 1);
      tick();
      seed_req = 1'b0;
      seed_val = 16'h0000;
      repeat (4) tick();

      push_chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
